mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Single-port memory arbiter shared by the instruction-fetch path (read-only) and the LSU data path (load/store) of the pipelined RV32I core. It replaces separate instruction and data memories with one unified memory port. It serialises requests through a 4-state FSM, favours data accesses with a starvation guard for fetch, and drives per-requester stall signals into the pipeline hazard logic. It sits between the IF/MEM stages and the external memory.

Parameters:
WIDTH, 32, address/data width
STARVE_MAX, 4, consecutive LSU grants allowed while a fetch is pending before fetch is forced
TIMEOUT, 64, maximum WAIT cycles before a bus error completion
CNT_W, 8, width of the internal timeout counter (must hold TIMEOUT)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_if_req  in  1  fetch request, held until o_if_done
i_if_addr  in  WIDTH  fetch address, stable while i_if_req
i_if_flush  in  1  mispredict flush; drops the pending fetch response
o_if_done  out  1  one-cycle fetch completion pulse
o_if_rdata  out  WIDTH  fetched instruction, valid with o_if_done, held after
o_if_stall  out  1  i_if_req & ~o_if_done
i_lsu_req  in  1  data request, held until o_lsu_done
i_lsu_we  in  1  1=store, 0=load
i_lsu_addr  in  WIDTH  data address
i_lsu_wdata  in  WIDTH  store data
i_lsu_bmask  in  4  byte enables
o_lsu_done  out  1  one-cycle data completion pulse
o_lsu_rdata  out  WIDTH  load data, valid with o_lsu_done, held after
o_lsu_stall  out  1  i_lsu_req & ~o_lsu_done
o_mem_req  out  1  one-cycle memory command strobe
o_mem_we  out  1  write enable with o_mem_req
o_mem_addr  out  WIDTH  registered command address
o_mem_wdata  out  WIDTH  registered write data
o_mem_bmask  out  4  registered byte mask (4'hF for fetch)
i_mem_ack  in  1  memory completion; rdata valid same cycle
i_mem_rdata  in  WIDTH  memory read data
o_bus_err  out  1  sticky timeout flag
o_perf_if_grants  out  32  fetch grant count (see optional feature)
o_perf_lsu_grants  out  32  LSU grant count
o_perf_stall_cycles  out  32  cycles with either stall high

Behaviour:
- Reset: FSM=IDLE; all outputs 0 (rdata regs, o_mem_* regs, o_bus_err, counters, starve counter, flush-drop flag). Reset mid-transaction abandons it, emits no done pulse, and ignores later i_mem_ack.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when no request is pending, stay. Only LSU pending: grant LSU. Only IF pending: grant IF. Both pending: grant LSU unless starve_cnt==STARVE_MAX, then grant IF. On grant, latch owner, addr, we (0 for IF), wdata, and bmask (4'hF for IF) into the o_mem_* regs, then go to ISSUE.
- ISSUE: o_mem_req=1 for exactly this cycle, then go to WAIT. i_mem_ack is ignored in ISSUE.
- WAIT: count cycles. On i_mem_ack, latch i_mem_rdata into the owner's rdata reg and go to RESP. If the count reaches TIMEOUT with no ack, set o_bus_err, load 0 into the owner's rdata, and go to RESP.
- RESP: pulse the owner's done for one cycle, then go to IDLE. Minimum latency: request seen in IDLE at cycle 0, ack at cycle 2, done at cycle 3.
- Starve counter: increments (saturating) on each LSU grant while i_if_req=1. Clears on an IF grant, or on an LSU grant with i_if_req=0.
- Flush: i_if_flush while IF owns ISSUE/WAIT/RESP sets a drop flag. The memory transaction completes, but o_if_done is suppressed and o_if_rdata is not updated. The flag clears on return to IDLE. A flush with no IF ownership has no effect. The stall is computed combinationally from i_if_req, so the pipeline deasserting the request after a flush ends the stall.
- Stores: o_lsu_rdata is unchanged on store completion.
- A requester re-asserting its request the cycle after done is treated as a new request in IDLE.

Optional Feature:
ARB_PERF_CNT_EN.
- Defined: the three 32-bit counters increment per grant / per stall cycle, wrap at 2^32, and clear on reset.
- Undefined: the counter ports still exist but are tied to 0, and no counter flops are built.

Test Plan:
- Lone fetch: i_if_req, addr 0x100; ack 1 cycle after o_mem_req with rdata 0x00500093. Required: o_mem_addr=0x100, bmask=F, o_if_done 3 cycles after req with o_if_rdata=0x00500093, o_if_stall high for exactly 3 cycles.
- Simultaneous requests: IF addr 0x104 and LSU store 0x2000 data 0xDEADBEEF mask 0x3, both raised in the same cycle. Required: LSU is issued first (we=1, mask=3), and IF is issued immediately after LSU done.
- Starvation: IF held pending with LSU re-requesting continuously. Required: 4 LSU grants, then the 5th grant goes to IF.
- Flush: IF granted, i_if_flush pulsed in WAIT, ack arrives. Required: no o_if_done pulse, o_if_rdata unchanged, FSM returns to IDLE.
- Timeout: LSU load with no ack. Required: after 64 WAIT cycles o_bus_err=1 (stays 1), o_lsu_done pulses with rdata 0; i_rst then clears o_bus_err.
- Reset mid-WAIT: assert i_rst during WAIT, then ack. Required: no done pulse, all outputs 0, next request handled normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by instruction fetch (read-only)
// and the LSU (load/store). Each transaction runs IDLE -> ISSUE -> WAIT -> RESP.
// Data accesses win ties. A starvation guard forces fetch after STARVE_MAX
// back-to-back LSU grants that each saw a fetch pending.
//
// Ports
//   i_clk, i_rst          : clock; synchronous active-high reset
//   i_if_*  / o_if_*      : fetch request/address/flush; done pulse, rdata, stall
//   i_lsu_* / o_lsu_*     : data request/we/addr/wdata/bmask; done pulse, rdata, stall
//   o_mem_*               : registered command (req strobe, we, addr, wdata, bmask)
//   i_mem_ack/i_mem_rdata : memory completion and read data (same cycle)
//   o_bus_err             : sticky WAIT-timeout flag
//   o_perf_*              : grant/stall counters, built only with ARB_PERF_CNT_EN
//                           defined; otherwise tied to 0
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  input  logic             i_if_flush,
  output logic             o_if_done,
  output logic [WIDTH-1:0] o_if_rdata,
  output logic             o_if_stall,
  input  logic             i_lsu_req,
  input  logic             i_lsu_we,
  input  logic [WIDTH-1:0] i_lsu_addr,
  input  logic [WIDTH-1:0] i_lsu_wdata,
  input  logic [3:0]       i_lsu_bmask,
  output logic             o_lsu_done,
  output logic [WIDTH-1:0] o_lsu_rdata,
  output logic             o_lsu_stall,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_bmask,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_bus_err,
  output logic [31:0]      o_perf_if_grants,
  output logic [31:0]      o_perf_lsu_grants,
  output logic [31:0]      o_perf_stall_cycles
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       bmask;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q;
  logic             owner_if_q;   // 1: fetch owns the port, 0: LSU
  logic [CNT_W-1:0] wait_cnt_q;
  logic [SW-1:0]    starve_q;
  logic             drop_q;

  logic             grant_lsu, grant_if, timeout_hit, resp_load, drop_now;
  logic [WIDTH-1:0] resp_data;

  // Fetch is forced only when both are pending and the LSU has had its run.
  assign grant_lsu   = (state_q == IDLE) && i_lsu_req &&
                       !(i_if_req && (starve_q == SW'(STARVE_MAX)));
  assign grant_if    = (state_q == IDLE) && i_if_req && !grant_lsu;
  assign timeout_hit = (state_q == WAIT) && !i_mem_ack &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign resp_load   = (state_q == WAIT) && (i_mem_ack || timeout_hit);
  assign resp_data   = i_mem_ack ? i_mem_rdata : '0;

  // A flush in the RESP cycle itself must still kill that cycle's done pulse,
  // so the registered flag is OR-ed with the live flush.
  assign drop_now = drop_q | (i_if_flush & owner_if_q & (state_q != IDLE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant_lsu || grant_if) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (resp_load) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      owner_if_q  <= 1'b0;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      o_bus_err   <= 1'b0;
      o_if_rdata  <= '0;
      o_lsu_rdata <= '0;
    end else begin
      state_q <= state_d;

      if (grant_lsu || grant_if) begin
        owner_if_q  <= grant_if;
        cmd_q.we    <= grant_lsu & i_lsu_we;
        cmd_q.addr  <= grant_if ? i_if_addr : i_lsu_addr;
        cmd_q.wdata <= grant_if ? '0 : i_lsu_wdata;
        cmd_q.bmask <= grant_if ? 4'hF : i_lsu_bmask;
      end

      if (grant_if)
        starve_q <= '0;
      else if (grant_lsu)
        starve_q <= !i_if_req ? '0 :
                    (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;

      if (state_q == ISSUE)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;

      if (timeout_hit) o_bus_err <= 1'b1;

      // Stores leave load data alone; a dropped fetch leaves fetch data alone.
      if (resp_load) begin
        if (owner_if_q && !drop_now)        o_if_rdata  <= resp_data;
        else if (!owner_if_q && !cmd_q.we)  o_lsu_rdata <= resp_data;
      end

      drop_q <= (state_q == RESP) ? 1'b0 : drop_now;
    end
  end

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_we    = cmd_q.we;
  assign o_mem_addr  = cmd_q.addr;
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_bmask = cmd_q.bmask;

  assign o_if_done   = (state_q == RESP) &&  owner_if_q && !drop_now;
  assign o_lsu_done  = (state_q == RESP) && !owner_if_q;
  assign o_if_stall  = i_if_req  & ~o_if_done;
  assign o_lsu_stall = i_lsu_req & ~o_lsu_done;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_lsu_q, perf_stall_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perf_if_q    <= '0;
      perf_lsu_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_if)                   perf_if_q    <= perf_if_q + 1'b1;
      if (grant_lsu)                  perf_lsu_q   <= perf_lsu_q + 1'b1;
      if (o_if_stall || o_lsu_stall)  perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign o_perf_if_grants    = perf_if_q;
  assign o_perf_lsu_grants   = perf_lsu_q;
  assign o_perf_stall_cycles = perf_stall_q;
`else
  assign o_perf_if_grants    = '0;
  assign o_perf_lsu_grants   = '0;
  assign o_perf_stall_cycles = '0;
`endif

endmodule
